// File: rtl/ariane_axi.sv
// Shared AXI channel payload, request/response bundle and spill-state types.
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;

  typedef enum logic [1:0] {
    SPILL_EMPTY = 2'd0,
    SPILL_ONE   = 2'd1,
    SPILL_TWO   = 2'd2
  } spill_state_e;

endpackage

// File: rtl/axi_spill_fifo2.sv
// Two-entry spill buffer for one valid/ready channel; every output and the
// input ready come straight from flops, so no comb path crosses the buffer.
module axi_spill_fifo2
  import ariane_axi::*;
#(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data
);

  spill_state_e state_q, state_d;
  data_t        head_q, tail_q;
  logic         in_ready_q, out_valid_q;
  logic         push, pop;
  logic         load_head, head_from_tail, load_tail;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

  // Occupancy transitions and payload steering
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    unique case (state_q)
      SPILL_EMPTY: begin
        if (push) begin
          state_d   = SPILL_ONE;
          load_head = 1'b1;
        end
      end
      SPILL_ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_d   = SPILL_TWO;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = SPILL_EMPTY;
        end
      end
      SPILL_TWO: begin
        if (pop) begin
          state_d        = SPILL_ONE;
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = SPILL_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SPILL_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SPILL_TWO);
      out_valid_q <= (state_d != SPILL_EMPTY);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) head_q <= head_from_tail ? tail_q : in_data;
      if (load_tail) tail_q <= in_data;
    end
  end

endmodule

// File: rtl/axi_req_spill.sv
// Registered AXI cut: a spill buffer on each of AW/W/AR/B/R plus optional
// outstanding-transaction counters built when AXI_REQ_SPILL_CNT_EN is defined.
module axi_req_spill
  import ariane_axi::*;
#(
  parameter type         req_t    = ariane_axi::req_t,
  parameter type         resp_t   = ariane_axi::resp_t,
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output req_t                mst_req_o,
  input  resp_t               mst_resp_i,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o
);

  aw_chan_t aw_data;
  w_chan_t  w_data;
  ar_chan_t ar_data;
  b_chan_t  b_data;
  r_chan_t  r_data;
  logic     aw_in_ready, w_in_ready, ar_in_ready, b_in_ready, r_in_ready;
  logic     aw_out_valid, w_out_valid, ar_out_valid, b_out_valid, r_out_valid;

  axi_spill_fifo2 #(.data_t(aw_chan_t)) i_aw (
    .clk_i, .rst_i,
    .in_valid (slv_req_i.aw_valid), .in_ready (aw_in_ready),  .in_data (slv_req_i.aw),
    .out_valid(aw_out_valid),       .out_ready(mst_resp_i.aw_ready), .out_data(aw_data)
  );

  axi_spill_fifo2 #(.data_t(w_chan_t)) i_w (
    .clk_i, .rst_i,
    .in_valid (slv_req_i.w_valid),  .in_ready (w_in_ready),   .in_data (slv_req_i.w),
    .out_valid(w_out_valid),        .out_ready(mst_resp_i.w_ready), .out_data(w_data)
  );

  axi_spill_fifo2 #(.data_t(ar_chan_t)) i_ar (
    .clk_i, .rst_i,
    .in_valid (slv_req_i.ar_valid), .in_ready (ar_in_ready),  .in_data (slv_req_i.ar),
    .out_valid(ar_out_valid),       .out_ready(mst_resp_i.ar_ready), .out_data(ar_data)
  );

  axi_spill_fifo2 #(.data_t(b_chan_t)) i_b (
    .clk_i, .rst_i,
    .in_valid (mst_resp_i.b_valid), .in_ready (b_in_ready),   .in_data (mst_resp_i.b),
    .out_valid(b_out_valid),        .out_ready(slv_req_i.b_ready), .out_data(b_data)
  );

  axi_spill_fifo2 #(.data_t(r_chan_t)) i_r (
    .clk_i, .rst_i,
    .in_valid (mst_resp_i.r_valid), .in_ready (r_in_ready),   .in_data (mst_resp_i.r),
    .out_valid(r_out_valid),        .out_ready(slv_req_i.r_ready), .out_data(r_data)
  );

  // Reassemble the bundles from the per-channel buffers
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_data;
    mst_req_o.aw_valid = aw_out_valid;
    mst_req_o.w        = w_data;
    mst_req_o.w_valid  = w_out_valid;
    mst_req_o.ar       = ar_data;
    mst_req_o.ar_valid = ar_out_valid;
    mst_req_o.b_ready  = b_in_ready;
    mst_req_o.r_ready  = r_in_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_in_ready;
    slv_resp_o.w_ready  = w_in_ready;
    slv_resp_o.ar_ready = ar_in_ready;
    slv_resp_o.b_valid  = b_out_valid;
    slv_resp_o.b        = b_data;
    slv_resp_o.r_valid  = r_out_valid;
    slv_resp_o.r        = r_data;
  end

`ifdef AXI_REQ_SPILL_CNT_EN
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic                aw_hs, b_hs, ar_hs, r_last_hs;
  logic [CntWidth-1:0] wr_cnt_q, rd_cnt_q;

  assign aw_hs     = aw_out_valid & mst_resp_i.aw_ready;
  assign b_hs      = b_out_valid & slv_req_i.b_ready;
  assign ar_hs     = ar_out_valid & mst_resp_i.ar_ready;
  assign r_last_hs = r_out_valid & slv_req_i.r_ready & r_data.last;

  // Saturating up/down counters; simultaneous inc and dec cancel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (aw_hs && !b_hs && wr_cnt_q != CntMax) begin
        wr_cnt_q <= wr_cnt_q + CntWidth'(1);
      end else if (b_hs && !aw_hs && wr_cnt_q != '0) begin
        wr_cnt_q <= wr_cnt_q - CntWidth'(1);
      end
      if (ar_hs && !r_last_hs && rd_cnt_q != CntMax) begin
        rd_cnt_q <= rd_cnt_q + CntWidth'(1);
      end else if (r_last_hs && !ar_hs && rd_cnt_q != '0) begin
        rd_cnt_q <= rd_cnt_q - CntWidth'(1);
      end
    end
  end

  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
`else
  assign wr_outstanding_o = '0;
  assign rd_outstanding_o = '0;
`endif

endmodule
